// File: rtl/shift_arbiter.sv
// shift_arbiter
// -------------
// Lets two requesters share one 32-bit shifter. It supports two operations:
// a logical left shift (SLL) and an arithmetic right shift (SRA).
// Requests are arbitrated round-robin. The winning operands are latched,
// shifted for exactly one cycle, and the result is held with a
// valid/ready handshake.
//
// Optional feature: define SHIFT_ARB_B2B_EN to allow a new request to be
// accepted in the same cycle as the response handshake. The state then goes
// straight back to EXEC without passing through IDLE. With the macro
// undefined, requests are accepted only in IDLE.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   reqN_valid/ready      request handshake for requester N (N = 0, 1)
//   reqN_data/shamt/op    operand, shift amount 0..31, op (0=SLL, 1=SRA)
//   resp_valid/ready      result handshake
//   resp_data, resp_id    registered result and the id of its requester
//   busy                  high whenever the arbiter is not idle
module shift_arbiter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic               req1_op,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DATA_W-1:0]  resp_data,
  output logic               resp_id,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic               last_grant;
  logic [DATA_W-1:0]  data_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic               op_q;
  logic               id_q;

  logic               handshake;
  logic               arb_en;
  logic               grant0;
  logic               grant1;
  logic [DATA_W-1:0]  sel_data;
  logic [SHAMT_W-1:0] sel_shamt;
  logic               sel_op;
  logic [DATA_W-1:0]  shift_result;

  assign handshake = resp_valid & resp_ready;

`ifdef SHIFT_ARB_B2B_EN
  assign arb_en = (state == IDLE) | ((state == RESP) & handshake);
`else
  assign arb_en = (state == IDLE);
`endif

  // A tie goes to the port that did not win last time.
  // last_grant resets to 1, so port 0 wins the first tie.
  assign grant0 = arb_en & req0_valid & (~req1_valid | last_grant);
  assign grant1 = arb_en & req1_valid & (~req0_valid | ~last_grant);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Shift helper: SRA fills vacated bits with the sign bit, SLL fills with zero.
  function automatic logic [DATA_W-1:0] do_shift(
    input logic [DATA_W-1:0]  d,
    input logic [SHAMT_W-1:0] s,
    input logic               op
  );
    if (op) begin
      do_shift = DATA_W'($signed(d) >>> s);
    end else begin
      do_shift = d << s;
    end
  endfunction

  // Select the operands of the granted requester and compute the result
  // from the latched operands.
  always_comb begin
    sel_data     = {DATA_W{1'b0}};
    sel_shamt    = {SHAMT_W{1'b0}};
    sel_op       = 1'b0;
    if (grant1) begin
      sel_data  = req1_data;
      sel_shamt = req1_shamt;
      sel_op    = req1_op;
    end else begin
      sel_data  = req0_data;
      sel_shamt = req0_shamt;
      sel_op    = req0_op;
    end
    shift_result = do_shift(data_q, shamt_q, op_q);
  end

  // Control FSM, operand registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      data_q     <= {DATA_W{1'b0}};
      shamt_q    <= {SHAMT_W{1'b0}};
      op_q       <= 1'b0;
      id_q       <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= {DATA_W{1'b0}};
      resp_id    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            data_q     <= sel_data;
            shamt_q    <= sel_shamt;
            op_q       <= sel_op;
            id_q       <= grant1;
            last_grant <= grant1;
            state      <= EXEC;
            busy       <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        EXEC: begin
          resp_data  <= shift_result;
          resp_id    <= id_q;
          resp_valid <= 1'b1;
          state      <= RESP;
          busy       <= 1'b1;
        end
        RESP: begin
          if (handshake) begin
            resp_valid <= 1'b0;
`ifdef SHIFT_ARB_B2B_EN
            if (grant0 | grant1) begin
              data_q     <= sel_data;
              shamt_q    <= sel_shamt;
              op_q       <= sel_op;
              id_q       <= grant1;
              last_grant <= grant1;
              state      <= EXEC;
              busy       <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end else begin
            state <= RESP;
            busy  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter. It combines directed cases with
// random traffic. Outputs are compared each falling edge against a
// transaction-level reference model.
module tb_shift_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data = 32'd0, req1_data = 32'd0;
  logic [4:0]  req0_shamt = 5'd0, req1_shamt = 5'd0;
  logic        req0_op = 1'b0, req1_op = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_id;
  logic        busy;

  always #5 clock = ~clock;

  shift_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_shamt(req0_shamt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_shamt(req1_shamt), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference shift done with multiplication and floor division.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input bit op);
    longint p, v, q;
    logic [63:0] r;
    p = 1;
    for (int i = 0; i < s; i++) p = p * 2;
    if (!op) begin
      q = longint'(d) * p;
    end else begin
      v = longint'(d);
      if (d[31]) v = v - 64'sh1_0000_0000;
      if (v >= 0) q = v / p;
      else q = -((-v + p - 1) / p);
    end
    r = q;
    return r[31:0];
  endfunction

  // Reference model: phase 0 = idle, 1 = operation latched, 2 = result held.
  int          m_phase = 0;
  bit          m_last = 1'b1;
  logic [31:0] p_data = 32'd0;
  int          p_shamt = 0;
  bit          p_op = 1'b0, p_id = 1'b0;
  logic [31:0] m_out_data = 32'd0;
  bit          m_out_id = 1'b0;
  bit          chk_en = 1'b0;
  int          cyc = 0;
  int          acc_cyc[$];
  int          acc_id[$];

  always @(negedge clock) begin : model
    bit arb, g0, g1;
    cyc++;
    arb = (m_phase == 0);
`ifdef SHIFT_ARB_B2B_EN
    if (m_phase == 2 && resp_ready) arb = 1'b1;
`endif
    g0 = arb && req0_valid && (!req1_valid || m_last);
    g1 = arb && req1_valid && (!req0_valid || !m_last);
    if (chk_en) begin
      check("req0_ready", 32'(req0_ready), 32'(g0));
      check("req1_ready", 32'(req1_ready), 32'(g1));
      check("resp_valid", 32'(resp_valid), 32'(m_phase == 2));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("resp_data", resp_data, m_out_data);
      check("resp_id", 32'(resp_id), 32'(m_out_id));
    end
    if (reset) begin
      m_phase = 0; m_last = 1'b1; m_out_data = 32'd0; m_out_id = 1'b0;
    end else if (m_phase == 1) begin
      m_out_data = ref_shift(p_data, p_shamt, p_op);
      m_out_id = p_id;
      m_phase = 2;
    end else begin
      if (m_phase == 2 && resp_ready) m_phase = 0;
      if (g0 || g1) begin
        p_data  = g1 ? req1_data : req0_data;
        p_shamt = g1 ? int'(req1_shamt) : int'(req0_shamt);
        p_op    = g1 ? req1_op : req0_op;
        p_id    = g1;
        m_last  = g1;
        m_phase = 1;
        acc_cyc.push_back(cyc);
        acc_id.push_back(int'(g1));
      end
    end
  end

  task automatic drive(input int port, input logic [31:0] d, input int s, input bit op);
    if (port == 0) begin
      req0_data = d; req0_shamt = 5'(s); req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_data = d; req1_shamt = 5'(s); req1_op = op; req1_valid = 1'b1;
    end
  endtask

  // Present a request and wait (bounded) for it to be accepted.
  task automatic send(input int port, input logic [31:0] d, input int s, input bit op);
    int n;
    bit ok;
    n = acc_id.size();
    ok = 1'b0;
    drive(port, d, s, op);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clock);
      if (acc_id.size() > n) ok = 1'b1;
    end
    check("accept_seen", 32'(ok), 32'd1);
    if (ok) check("accept_port", 32'(acc_id[n]), 32'(port));
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Count clock edges after the accept edge until resp_valid is seen.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic do_op(input int port, input logic [31:0] d, input int s, input bit op,
                       input logic [31:0] exp);
    int lat;
    resp_ready = 1'b1;
    send(port, d, s, op);
    wait_resp(lat);
    check("latency_cycles", 32'(lat + 1), 32'd2);
    check("dir_data", resp_data, exp);
    check("dir_id", 32'(resp_id), 32'(port));
    @(posedge clock); #1;
  endtask

  task automatic cycle();
    @(posedge clock); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int n, lat, s, gap;
    logic [31:0] expv;
    repeat (2) @(posedge clock);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    chk_en = 1'b1;
    reset = 1'b0;

    // Directed shift cases.
    do_op(0, 32'h8000_0000, 4, 1'b1, 32'hF800_0000);
    do_op(1, 32'h0000_0001, 31, 1'b0, 32'h8000_0000);
    do_op(0, 32'h7FFF_FFFF, 31, 1'b1, 32'h0000_0000);
    do_op(1, 32'hDEAD_BEEF, 0, 1'b1, 32'hDEAD_BEEF);
    do_op(0, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF);
    do_op(1, 32'h8000_0001, 31, 1'b1, 32'hFFFF_FFFF);

    // Fairness: both valid continuously after reset, so grants go 0,1,0,1.
    reset = 1'b1; cycle(); reset = 1'b0;
    n = acc_id.size();
    drive(0, 32'h1234_5678, 3, 1'b0);
    drive(1, 32'h8765_4321, 7, 1'b1);
    for (int i = 0; i < 40 && acc_id.size() < n + 4; i++) cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("fair_count", 32'(acc_id.size() >= n + 4), 32'd1);
    for (int k = 0; k < 4 && n + k < acc_id.size(); k++)
      check("fair_order", 32'(acc_id[n + k]), 32'(k % 2));
    repeat (4) cycle();

    // Response stall: five cycles without resp_ready.
    resp_ready = 1'b0;
    send(0, 32'hC0FF_EE00, 8, 1'b1);
    wait_resp(lat);
    expv = ref_shift(32'hC0FF_EE00, 8, 1'b1);
    drive(1, 32'h0000_00FF, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_valid", 32'(resp_valid), 32'd1);
      check("stall_data", resp_data, expv);
      check("stall_ready0", 32'(req0_ready), 32'd0);
      check("stall_ready1", 32'(req1_ready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
    end
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    cycle();
    check("release_busy", 32'(busy), 32'd0);
    check("release_valid", 32'(resp_valid), 32'd0);

    // Reset while in EXEC drops the operation; port 0 wins the next tie.
    send(1, 32'h0F0F_0F0F, 2, 1'b0);
    reset = 1'b1;
    drive(0, 32'hAAAA_5555, 5, 1'b1);
    drive(1, 32'h5555_AAAA, 6, 1'b0);
    cycle();
    check("rstx_valid", 32'(resp_valid), 32'd0);
    check("rstx_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    n = acc_id.size();
    for (int i = 0; i < 20 && acc_id.size() == n; i++) cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rstx_first_seen", 32'(acc_id.size() > n), 32'd1);
    if (acc_id.size() > n) check("rstx_first_port", 32'(acc_id[n]), 32'd0);
    repeat (4) cycle();

    // Random traffic; the reference model checks every cycle.
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_data = $urandom; req1_data = $urandom;
      s = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 31 : 0) : $urandom_range(0, 31);
      req0_shamt = 5'(s);
      req1_shamt = 5'($urandom_range(0, 31));
      req0_op = 1'($urandom_range(0, 1));
      req1_op = 1'($urandom_range(0, 1));
      resp_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    repeat (5) cycle();

    // Throughput with req0 always valid and an always-ready consumer.
`ifdef SHIFT_ARB_B2B_EN
    gap = 2;
`else
    gap = 3;
`endif
    n = acc_cyc.size();
    drive(0, 32'h0000_0F00, 4, 1'b0);
    repeat (20) cycle();
    req0_valid = 1'b0;
    check("tput_count", 32'(acc_cyc.size() >= n + 5), 32'd1);
    for (int k = n + 1; k < acc_cyc.size(); k++)
      check("tput_gap", 32'(acc_cyc[k] - acc_cyc[k - 1]), 32'(gap));
    repeat (5) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit shift datapath (logical left shift SLL, arithmetic right shift SRA) between two requesters.
- Round-robin arbitration; operands latched on accept; one registered result returned with a valid/ready handshake.
- Sits between the ALU issue logic and the shift datapath, so two issuing sources can use a single shifter.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- SHAMT_W, 5, shift-amount width; only 5 is supported.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle when high with req0_valid
- req0_data  in  32  operand
- req0_shamt  in  5  shift amount 0..31
- req0_op  in  1  0=SLL, 1=SRA
- req1_valid, req1_ready, req1_data, req1_shamt, req1_op  same as requester 0, for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_data  out  32  shifted result
- resp_id  out  1  index of the requester that issued the result
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset is synchronous: all outputs 0, state=IDLE, last_grant=1 (port 0 wins the first tie), operand registers 0.
- States:
  - IDLE: waiting for a request.
  - EXEC: operands held in registers.
  - RESP: result held.
- IDLE:
  - reqN_ready = grant to N, given only when reqN_valid=1.
  - If exactly one request is valid, it is granted.
  - If both are valid, grant !last_grant.
  - On grant, latch data, shamt, op and id; update last_grant=id; go to EXEC.
  - With no valid request, stay in IDLE.
- reqN_ready is combinational from state, valids and last_grant; it is never high outside IDLE (except as allowed by the optional feature). Both readys are never high together.
- EXEC (exactly one cycle):
  - result_reg = op ? SRA(data, shamt) : SLL(data, shamt).
  - SRA fills vacated bits with data[31]; SLL fills with 0.
  - shamt=0 passes the operand unchanged.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_data and resp_id are stable until the handshake.
  - On resp_valid & resp_ready, go to IDLE.
  - Otherwise hold indefinitely; no new request is accepted.
- Latency: accept in cycle N; resp_valid=1 from cycle N+2. If resp_ready is held high, the result is consumed in N+2 and the next accept is N+3 (steady throughput of one result per 3 cycles).
- resp_valid is 0 in IDLE and EXEC. resp_data is registered and keeps its last value outside RESP.
- Requester input changes while not granted are ignored.
- Reset asserted in any state: the next edge goes to IDLE and the in-flight operation is dropped without a response; last_grant returns to 1.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…

Optional Feature:
- Macro: SHIFT_ARB_B2B_EN.
- Defined:
  - In RESP, when resp_valid & resp_ready, arbitration runs the same cycle using the IDLE rules. A granted request is latched and the state goes to EXEC directly, skipping IDLE.
  - reqN_ready may be high in RESP only in that handshake cycle.
  - Throughput with a continuously ready consumer: one result per 2 cycles.
- Undefined: behaviour exactly as above; readys are never high outside IDLE.

Test Plan:
- Reset, then req0 SRA data=0x80000000 shamt=4 -> req0_ready high in accept cycle N; resp_valid at N+2; resp_data=0xF8000000; resp_id=0.
- req1 SLL data=0x00000001 shamt=31 -> resp_data=0x80000000, resp_id=1. Then SRA 0x7FFFFFFF shamt=31 -> 0x00000000. Then shamt=0 on 0xDEADBEEF -> 0xDEADBEEF.
- Both valid continuously for 4 grants -> grant order 0,1,0,1; readys are one-hot; every resp_id matches its grant.
- resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_data stable, both readys 0, busy=1; resp_ready=1 -> IDLE next cycle.
- Reset asserted during EXEC -> next cycle state=IDLE, resp_valid=0, busy=0; with both requesters valid afterwards, port 0 is granted first.
- With SHIFT_ARB_B2B_EN and resp_ready held 1, req0 continuously valid -> accepts every 2 cycles. Without the macro -> accepts every 3 cycles.
